mem_fill_check: RTL and testbench
=================================

Name: mem_fill_check

Overview:
Parametrised memory fill-and-verify engine. Owns one single-port synchronous RAM. On `start` it:
- writes a selectable test pattern to every word;
- reads every word back and compares it against the regenerated pattern;
- reports pass/fail, a saturating error count and the first failing address.

While idle, a host read port exposes RAM contents for on-board debug (DE10 SignalTap/LED display).

Parameters:
DATA_W, 32, RAM word width (8..64)
ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W words
RD_LAT, 1, RAM read latency in cycles (1 or 2; 2 = registered output)
ERR_W, 16, error counter width

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin run; sampled only in IDLE/DONE
mode  in  2  pattern select, latched at start
seed  in  DATA_W  pattern seed, latched at start
inj_en  in  1  fault injection enable, latched at start
inj_addr  in  ADDR_W  word whose written value gets bit 0 inverted, latched at start
busy  out  1  high from cycle after start accept until DONE
done  out  1  one-cycle pulse at end of run
pass  out  1  valid when done; 1 iff err_count==0; held until next start
err_count  out  ERR_W  mismatching words, saturating; held until next start
first_err_valid  out  1  at least one mismatch this run
first_err_addr  out  ADDR_W  address of first mismatch; 0 if none
rd_req  in  1  host read request (honoured in IDLE/DONE only)
rd_addr  in  ADDR_W  host read address
rd_data  out  DATA_W  host read data
rd_valid  out  1  rd_data valid, RD_LAT cycles after accepted rd_req

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs reset to 0; FSM returns to IDLE. RAM contents are undefined after reset.
- Patterns, where a = word address zero-extended to DATA_W:
  - mode 0: a
  - mode 1: ~a
  - mode 2: seed
  - mode 3: seed rotated left by (a mod DATA_W)
- Fault injection: if inj_en is latched, the FILL write at inj_addr uses pattern ^ 1. The compare uses the clean pattern.
- FSM states and transitions:
  - IDLE -> FILL on start.
  - FILL: one write per cycle, addresses 0..DEPTH-1. After the write to DEPTH-1, go to READ.
  - READ: one read per cycle, addresses 0..DEPTH-1. The expected pattern is delayed RD_LAT cycles alongside the address. After the read of DEPTH-1, go to DRAIN.
  - DRAIN: RD_LAT cycles so the last read data can be compared, then go to DONE.
  - DONE: done=1 for this single cycle. Next state is IDLE, or FILL if start=1 in this cycle.
- Timing: start accepted at edge k gives:
  - FILL in cycles k+1..k+DEPTH;
  - READ in cycles k+DEPTH+1..k+2*DEPTH;
  - done=1 in cycle k+2*DEPTH+RD_LAT+1.
- busy and done:
  - busy=1 from FILL through DRAIN; 0 in IDLE and DONE.
  - start while busy is ignored.
  - done and busy are never high together.
- Result updates:
  - At start accept: err_count, first_err_valid and first_err_addr clear; pass clears to 0.
  - Each compare mismatch: err_count increments, saturating at 2**ERR_W-1. The first mismatch sets first_err_valid and captures first_err_addr.
  - pass is updated in the DONE cycle.
- Host read port:
  - An rd_req in IDLE/DONE drives the RAM address.
  - rd_valid pulses RD_LAT cycles later, with the corresponding rd_data.
  - rd_req while busy is dropped (no rd_valid).
  - start and rd_req in the same cycle: start wins and rd_req is dropped.
  - rd_data holds its last value between reads.
- Address counter: ADDR_W bits. The end-of-phase check is counter==DEPTH-1, never a wrap to 0, so DEPTH=2**ADDR_W is covered with no extra bit.
- Reset mid-run: busy drops immediately (asynchronously) and no done is produced. A new start after reset performs a complete run.

Decomposition:
- Package mem_fill_pkg holds:
  - mode encodings (PAT_ADDR=0, PAT_NADDR=1, PAT_SEED=2, PAT_ROT=3);
  - the FSM state enum (IDLE, FILL, READ, DRAIN, DONE);
  - the pattern-generation function, parametrised by DATA_W/ADDR_W.
- One sub-module, sp_ram: single-port synchronous RAM (DATA_W x DEPTH, RD_LAT). Written as an inferable M9K-compatible template with no reset on the array.
- Address/write-data/read muxing between the engine and the host port stays in mem_fill_check.

Test Plan:
(DATA_W=32, ADDR_W=4, DEPTH=16, RD_LAT=1 unless noted)
- Clean run, mode 0: start pulse at edge k -> busy high for cycles k+1..k+33, done in cycle k+34, pass=1, err_count=0, first_err_valid=0. Host reads of addr 5 and 15 -> rd_data 0x00000005 and 0x0000000F, each one cycle after rd_req.
- Mode 3, seed=0x80000001 -> pass=1. Host read of addr 1 -> 0x00000003; addr 4 -> 0x00000018.
- Fault injection: inj_en=1, inj_addr=7, mode 1 -> err_count=1, first_err_addr=7, pass=0. Host read of addr 7 -> 0xFFFFFFF9.
- Saturation with ERR_W=2: force all compares to mismatch via a test override of the expected pattern -> err_count saturates at 3, not 0; first_err_addr=0.
- Control corner cases:
  - start re-asserted in cycle k+10 -> ignored; done still at k+34.
  - start held high through DONE -> next run begins the cycle after done.
  - rd_req while busy -> no rd_valid.
- Reset and latency: rst asserted in cycle k+20 -> busy=0 and done=0 immediately; next start gives a full run with pass=1. Repeat the clean run with RD_LAT=2 -> done in cycle k+35.

Source files
------------

// File: rtl/mem_fill_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_fill_pkg: pattern encodings, engine states, pattern generator    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_fill_pkg;

  localparam logic [1:0] PAT_ADDR  = 2'd0;
  localparam logic [1:0] PAT_NADDR = 2'd1;
  localparam logic [1:0] PAT_SEED  = 2'd2;
  localparam logic [1:0] PAT_ROT   = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Computed at 64 bits; callers truncate to their word width.
  function automatic logic [63:0] gen_pattern(input logic [1:0] mode,
                                              input logic [63:0] seed,
                                              input logic [63:0] addr,
                                              input int unsigned width);
    logic [63:0] mask;
    logic [63:0] s;
    logic [63:0] rot;
    logic [63:0] rotl;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    s    = seed & mask;
    rot  = addr % 64'(width);
    rotl = ((s << rot) | (s >> (64'(width) - rot))) & mask;
    case (mode)
      PAT_ADDR:  return addr;
      PAT_NADDR: return ~addr & mask;
      PAT_SEED:  return s;
      default:   return rotl;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_fill_check_sp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sp_ram: single-port synchronous RAM, 1 or 2 cycle read latency       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int c_DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
    r_q <= r_mem[addr];
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] r_q2;
      always_ff @(posedge clk) r_q2 <= r_q;
      assign rdata = r_q2;
    end else begin : g_lat1
      assign rdata = r_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_fill_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_fill_check: fill RAM with a pattern, read back, report errors    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
import mem_fill_pkg::*;

module mem_fill_check #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int RD_LAT       = 1,
  parameter int ERR_W        = 16,
  parameter bit TEST_EXP_INV = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              inj_en,
  input  logic [ADDR_W-1:0] inj_addr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam logic [ADDR_W-1:0] c_LAST = '1;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_drain;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_seed;
  logic              r_inj_en;
  logic [ADDR_W-1:0] r_inj_addr;
  logic [DATA_W-1:0] r_rd_hold;

  logic              w_start_acc, w_host_acc, w_rd_issue, w_inj_hit, w_mismatch;
  logic [DATA_W-1:0] w_pat, w_exp;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  // Compare and host-read pipelines track RAM read latency.
  logic              r_cv    [RD_LAT];
  logic [DATA_W-1:0] r_cexp  [RD_LAT];
  logic [ADDR_W-1:0] r_caddr [RD_LAT];
  logic              r_hv    [RD_LAT];

  assign w_start_acc = start && (r_state == IDLE || r_state == DONE);
  assign w_inj_hit   = r_inj_en && (r_addr == r_inj_addr);
  assign w_pat       = DATA_W'(gen_pattern(r_mode, 64'(r_seed), 64'(r_addr), DATA_W));
  assign w_exp       = w_pat ^ {DATA_W{TEST_EXP_INV}};
  assign w_mismatch  = r_cv[RD_LAT-1] && (ram_rdata != r_cexp[RD_LAT-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = FILL;
      FILL:    if (r_addr == c_LAST) w_next = READ;
      READ:    if (r_addr == c_LAST) w_next = DRAIN;
      DRAIN:   if (r_drain == 2'(RD_LAT - 1)) w_next = DONE;
      DONE:    w_next = start ? FILL : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = rd_addr;
    ram_wdata  = w_pat;
    w_rd_issue = 1'b0;
    w_host_acc = 1'b0;
    case (r_state)
      FILL: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = r_addr;
        ram_wdata = w_pat ^ DATA_W'(w_inj_hit);
      end
      READ: begin
        busy       = 1'b1;
        ram_addr   = r_addr;
        w_rd_issue = 1'b1;
      end
      DRAIN: busy = 1'b1;
      IDLE, DONE: begin
        done       = (r_state == DONE);
        w_host_acc = rd_req && !start;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_drain    <= '0;
      r_mode     <= '0;
      r_seed     <= '0;
      r_inj_en   <= 1'b0;
      r_inj_addr <= '0;
    end else begin
      if (w_start_acc) begin
        r_addr     <= '0;
        r_mode     <= mode;
        r_seed     <= seed;
        r_inj_en   <= inj_en;
        r_inj_addr <= inj_addr;
      end else if (r_state == FILL || r_state == READ) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      r_drain <= (r_state == DRAIN) ? r_drain + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_cv[i]    <= 1'b0;
        r_cexp[i]  <= '0;
        r_caddr[i] <= '0;
        r_hv[i]    <= 1'b0;
      end
    end else begin
      r_cv[0]    <= w_rd_issue;
      r_cexp[0]  <= w_exp;
      r_caddr[0] <= r_addr;
      r_hv[0]    <= w_host_acc;
      for (int i = 1; i < RD_LAT; i++) begin
        r_cv[i]    <= r_cv[i-1];
        r_cexp[i]  <= r_cexp[i-1];
        r_caddr[i] <= r_caddr[i-1];
        r_hv[i]    <= r_hv[i-1];
      end
    end
  end

  // pass is made visible in the DONE cycle, folding in the final compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      pass            <= 1'b0;
      r_rd_hold       <= '0;
    end else begin
      if (w_start_acc) begin
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_addr  <= '0;
        pass            <= 1'b0;
      end else begin
        if (w_mismatch) begin
          if (err_count != '1) err_count <= err_count + ERR_W'(1);
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_addr  <= r_caddr[RD_LAT-1];
          end
        end
        if (r_state == DRAIN && w_next == DONE)
          pass <= (err_count == '0) && !w_mismatch;
      end
      if (r_hv[RD_LAT-1]) r_rd_hold <= ram_rdata;
    end
  end

  assign rd_valid = r_hv[RD_LAT-1];
  assign rd_data  = r_hv[RD_LAT-1] ? ram_rdata : r_rd_hold;

  sp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_fill_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_fill_check: directed + randomized bench for mem_fill_check    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_fill_check;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start2 = 1'b0, start3 = 1'b0;
  logic [1:0]  mode = '0;
  logic [31:0] seed = '0;
  logic        inj_en = 1'b0;
  logic [3:0]  inj_addr = '0;
  logic        rd_req = 1'b0, rd_req2 = 1'b0, rd_req3 = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic        busy, done, pass, fev, rd_valid;
  logic [15:0] err;
  logic [3:0]  fea;
  logic [31:0] rd_data;
  logic        busy2, done2, pass2, fev2, rd_valid2;
  logic [15:0] err2;
  logic [3:0]  fea2;
  logic [31:0] rd_data2;
  logic        busy3, done3, pass3, fev3, rd_valid3;
  logic [1:0]  err3;
  logic [3:0]  fea3;
  logic [31:0] rd_data3;

  int checks = 0;
  int failures = 0;
  logic [31:0] mem_m [16];

  always #5 clk = ~clk;

  mem_fill_check #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .ERR_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .inj_en(inj_en), .inj_addr(inj_addr), .busy(busy), .done(done),
    .pass(pass), .err_count(err), .first_err_valid(fev), .first_err_addr(fea),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid));

  mem_fill_check #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .ERR_W(16)) u_lat2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode), .seed(seed),
    .inj_en(inj_en), .inj_addr(inj_addr), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .first_err_valid(fev2), .first_err_addr(fea2),
    .rd_req(rd_req2), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2));

  mem_fill_check #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .ERR_W(2), .TEST_EXP_INV(1'b1)) u_sat (
    .clk(clk), .rst(rst), .start(start3), .mode(mode), .seed(seed),
    .inj_en(inj_en), .inj_addr(inj_addr), .busy(busy3), .done(done3),
    .pass(pass3), .err_count(err3), .first_err_valid(fev3), .first_err_addr(fea3),
    .rd_req(rd_req3), .rd_addr(rd_addr), .rd_data(rd_data3), .rd_valid(rd_valid3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pat(input logic [1:0] m, input logic [31:0] sd, input int a);
    int r;
    logic [31:0] av;
    r  = a % 32;
    av = 32'(a);
    case (m)
      2'd0:    return av;
      2'd1:    return ~av;
      2'd2:    return sd;
      default: return (r == 0) ? sd : ((sd << r) | (sd >> (32 - r)));
    endcase
  endfunction

  // One full run on the main instance, checking timing and results at done.
  task automatic run_main(input logic [1:0] m, input logic [31:0] sd, input logic ie,
                          input logic [3:0] ia, input bit restart10, input bit rd_with_start);
    int s, busy_n, done_at, rdv_n, overlap;
    @(negedge clk);
    mode = m; seed = sd; inj_en = ie; inj_addr = ia;
    start = 1'b1; rd_req = rd_with_start; rd_addr = 4'd2;
    @(negedge clk);
    start = 1'b0; rd_req = 1'b0;
    for (int a = 0; a < 16; a++)
      mem_m[a] = model_pat(m, sd, a) ^ ((ie && a == int'(ia)) ? 32'd1 : 32'd0);
    s = 1; busy_n = 0; done_at = 0; rdv_n = 0; overlap = 0;
    while (done_at == 0 && s <= 100) begin
      if (busy) busy_n++;
      if (rd_valid) rdv_n++;
      if (busy && done) overlap++;
      if (done) done_at = s;
      else begin
        start   = restart10 && (s == 9);
        rd_req  = (s == 5);
        rd_addr = 4'd3;
        @(negedge clk);
        s++;
      end
    end
    start = 1'b0; rd_req = 1'b0;
    chk("done_cycle", done_at, 34);
    chk("busy_cycles", busy_n, 33);
    chk("busy_done_overlap", overlap, 0);
    chk("rd_valid_while_busy", rdv_n, 0);
    chk("pass", pass, !ie);
    chk("err_count", err, ie ? 1 : 0);
    chk("first_err_valid", fev, ie);
    chk("first_err_addr", fea, ie ? ia : 4'd0);
  endtask

  task automatic host_rd(input logic [3:0] a);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_req = 1'b0;
    chk("rd_valid", rd_valid, 1);
    chk("rd_data", rd_data, mem_m[a]);
    @(negedge clk);
    chk("rd_valid_pulse", rd_valid, 0);
    chk("rd_data_hold", rd_data, mem_m[a]);
  endtask

  initial begin
    int s, d;
    logic [3:0] ra;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;

    // Clean mode 0 with ignored restart and a start-coincident rd_req.
    run_main(2'd0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b1);
    host_rd(4'd5);
    host_rd(4'd15);
    run_main(2'd3, 32'h8000_0001, 1'b0, 4'd0, 1'b0, 1'b0);
    host_rd(4'd1);
    host_rd(4'd4);
    run_main(2'd1, 32'h0, 1'b1, 4'd7, 1'b0, 1'b0);
    host_rd(4'd7);
    chk("inj_read_value", rd_data, 32'hFFFF_FFF9);

    // start held high through DONE: next run starts immediately.
    @(negedge clk);
    mode = 2'd2; seed = 32'hA5A5_1234; inj_en = 1'b0; start = 1'b1;
    s = 0;
    while (!done && s < 100) begin @(negedge clk); s++; end
    chk("hold_first_done", done, 1);
    @(negedge clk);
    chk("hold_restart_busy", busy, 1);
    start = 1'b0;
    s = 0;
    while (!done && s < 100) begin @(negedge clk); s++; end
    chk("hold_second_done_cycle", s, 33);
    chk("hold_second_pass", pass, 1);

    // Asynchronous reset mid-run.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    run_main(2'd0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Randomized runs against the reference model.
    for (int r = 0; r < 6; r++) begin
      run_main(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        ra = 4'($urandom_range(0, 15));
        host_rd(ra);
      end
    end

    // RD_LAT=2 instance: timing and host read latency.
    @(negedge clk);
    mode = 2'd0; inj_en = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    s = 1; d = 0;
    while (d == 0 && s <= 100) begin
      if (done2) d = s;
      else begin @(negedge clk); s++; end
    end
    chk("lat2_done_cycle", d, 35);
    chk("lat2_pass", pass2, 1);
    chk("lat2_busy_at_done", busy2, 0);
    chk("lat2_err", err2, 0);
    chk("lat2_fev", fev2, 0);
    chk("lat2_fea", fea2, 0);
    @(negedge clk);
    rd_req2 = 1'b1; rd_addr = 4'd5;
    @(negedge clk);
    rd_req2 = 1'b0;
    chk("lat2_rd_valid_early", rd_valid2, 0);
    @(negedge clk);
    chk("lat2_rd_valid", rd_valid2, 1);
    chk("lat2_rd_data", rd_data2, 32'h5);

    // ERR_W=2 instance with every compare forced to mismatch.
    @(negedge clk);
    mode = 2'($urandom_range(0, 3)); seed = $urandom; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    s = 0;
    while (!done3 && s < 100) begin @(negedge clk); s++; end
    chk("sat_done", done3, 1);
    chk("sat_err", err3, 3);
    chk("sat_fev", fev3, 1);
    chk("sat_fea", fea3, 0);
    chk("sat_pass", pass3, 0);
    chk("sat_busy", busy3, 0);
    chk("sat_rd_valid", rd_valid3, 0);
    chk("sat_rd_data", rd_data3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
